// File: rtl/rv32_muldiv_unit_if.sv
// Execute-stage to M-extension unit bundle: operands, control and registered result.
// The master modport belongs to the pipeline side, the slave modport to the functional unit.
interface rv32_muldiv_unit_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            stall_in;
  logic            flush_in;
  logic            valid_in;
  logic [2:0]      op_in;
  logic [XLEN-1:0] rs1_value_in;
  logic [XLEN-1:0] rs2_value_in;
  logic [4:0]      rd_in;
  logic            busy_out;
  logic            valid_out;
  logic [4:0]      rd_out;
  logic            rd_write_out;
  logic [XLEN-1:0] result_out;

  modport master (
    output stall_in, flush_in, valid_in, op_in, rs1_value_in, rs2_value_in, rd_in,
    input  busy_out, valid_out, rd_out, rd_write_out, result_out
  );

  modport slave (
    input  stall_in, flush_in, valid_in, op_in, rs1_value_in, rs2_value_in, rd_in,
    output busy_out, valid_out, rd_out, rd_write_out, result_out
  );
endinterface

// File: rtl/rv32_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide,
// BITS_PER_CYCLE bits retired per cycle, single-cycle divide-by-zero/overflow path.
module rv32_muldiv_unit #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input logic              clk,
  input logic              reset,
  rv32_muldiv_unit_if.slave bus
);
  localparam int unsigned ITER = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CNTW = $clog2(ITER + 1);
  localparam int unsigned K    = BITS_PER_CYCLE;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            r_state;
  logic [CNTW-1:0]   r_cnt;
  logic [2:0]        r_op;
  logic              r_neg;
  logic [XLEN-1:0]   r_opb;    // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] r_acc;    // {partial product | remainder, multiplier | quotient}
  logic [4:0]        r_rd;
  logic              r_valid;
  logic              r_rd_write;
  logic [XLEN-1:0]   r_result;

  logic              w_accept, w_sa, w_sb, w_a_neg, w_b_neg, w_div_zero, w_ovf, w_neg;
  logic [XLEN-1:0]   w_abs_a, w_abs_b, w_fast, w_hi, w_lo, w_dpick, w_result;
  logic [XLEN:0]     w_trial;
  logic [XLEN+K-1:0] w_sum;
  logic [2*XLEN-1:0] w_acc_next, w_prod;

  localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

  assign w_accept = bus.valid_in && !bus.stall_in && !bus.flush_in;
  assign w_sa     = (bus.op_in == 3'd1) || (bus.op_in == 3'd2) || (bus.op_in == 3'd4) ||
                    (bus.op_in == 3'd6);
  assign w_sb     = (bus.op_in == 3'd1) || (bus.op_in == 3'd4) || (bus.op_in == 3'd6);
  assign w_a_neg  = w_sa && bus.rs1_value_in[XLEN-1];
  assign w_b_neg  = w_sb && bus.rs2_value_in[XLEN-1];
  assign w_abs_a  = w_a_neg ? -bus.rs1_value_in : bus.rs1_value_in;
  assign w_abs_b  = w_b_neg ? -bus.rs2_value_in : bus.rs2_value_in;
  // Remainder takes the dividend's sign; product and quotient take the XOR.
  assign w_neg    = (bus.op_in == 3'd6) ? w_a_neg : (w_a_neg ^ w_b_neg);

  assign w_div_zero = bus.op_in[2] && (bus.rs2_value_in == '0);
  assign w_ovf      = ((bus.op_in == 3'd4) || (bus.op_in == 3'd6)) &&
                      (bus.rs1_value_in == MinVal) && (bus.rs2_value_in == '1);
  assign w_fast     = bus.op_in[1] ? (w_div_zero ? bus.rs1_value_in : '0)
                                   : (w_div_zero ? '1 : MinVal);

  always_comb begin
    w_hi       = r_acc[2*XLEN-1:XLEN];
    w_lo       = r_acc[XLEN-1:0];
    w_trial    = '0;
    w_sum      = '0;
    w_acc_next = r_acc;
    if (r_op[2]) begin
      for (int i = 0; i < int'(K); i++) begin
        w_trial = {w_hi, w_lo[XLEN-1]};
        w_lo    = {w_lo[XLEN-2:0], 1'b0};
        if (w_trial >= {1'b0, r_opb}) begin
          w_trial = w_trial - {1'b0, r_opb};
          w_lo[0] = 1'b1;
        end
        w_hi = w_trial[XLEN-1:0];
      end
      w_acc_next = {w_hi, w_lo};
    end else begin
      w_sum = {{K{1'b0}}, w_hi};
      for (int i = 0; i < int'(K); i++) begin
        if (w_lo[i]) w_sum = w_sum + ({{K{1'b0}}, r_opb} << i);
      end
      w_acc_next = {w_sum, w_lo[XLEN-1:K]};
    end
  end

  always_comb begin
    w_prod  = r_neg ? -w_acc_next : w_acc_next;
    w_dpick = r_op[1] ? w_acc_next[2*XLEN-1:XLEN] : w_acc_next[XLEN-1:0];
    if (r_op[2])                w_result = r_neg ? -w_dpick : w_dpick;
    else if (r_op[1:0] == 2'd0) w_result = w_prod[XLEN-1:0];
    else                        w_result = w_prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_op       <= '0;
      r_neg      <= 1'b0;
      r_opb      <= '0;
      r_acc      <= '0;
      r_rd       <= '0;
      r_valid    <= 1'b0;
      r_rd_write <= 1'b0;
      r_result   <= '0;
    end else if (bus.flush_in) begin
      r_state    <= StIdle;
      r_valid    <= 1'b0;
      r_rd_write <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_op  <= bus.op_in;
            r_rd  <= bus.rd_in;
            r_neg <= w_neg;
            r_cnt <= CNTW'(ITER);
            if (w_div_zero || w_ovf) begin
              r_result   <= w_fast;
              r_valid    <= 1'b1;
              r_rd_write <= (bus.rd_in != 5'd0);
              r_state    <= StDone;
            end else begin
              r_opb   <= bus.op_in[2] ? w_abs_b : w_abs_a;
              r_acc   <= {{XLEN{1'b0}}, (bus.op_in[2] ? w_abs_a : w_abs_b)};
              r_state <= StRun;
            end
          end
        end
        StRun: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt - CNTW'(1);
          if (r_cnt == CNTW'(1)) begin
            r_result   <= w_result;
            r_valid    <= 1'b1;
            r_rd_write <= (r_rd != 5'd0);
            r_state    <= StDone;
          end
        end
        StDone: begin
          if (!bus.stall_in) begin
            r_state    <= StIdle;
            r_valid    <= 1'b0;
            r_rd_write <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.busy_out     = ((r_state == StIdle) && w_accept) || (r_state == StRun);
  assign bus.valid_out    = r_valid;
  assign bus.rd_out       = r_rd;
  assign bus.rd_write_out = r_rd_write;
  assign bus.result_out   = r_result;
endmodule

// File: tb/tb_rv32_muldiv_unit.sv
// Self-checking bench: a 32-bit radix-2 unit and a 64-bit radix-16 unit driven from one stimulus
// set, with a vector table, randomised ops against an arithmetic model, and control-path sequences.
module tb_rv32_muldiv_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        stall, flush, v32, v64, sel;
  logic [2:0]  op;
  logic [63:0] a, b;
  logic [4:0]  rd;

  rv32_muldiv_unit_if #(.XLEN(32)) if32 ();
  rv32_muldiv_unit_if #(.XLEN(64)) if64 ();

  assign if32.stall_in = stall;  assign if64.stall_in = stall;
  assign if32.flush_in = flush;  assign if64.flush_in = flush;
  assign if32.valid_in = v32;    assign if64.valid_in = v64;
  assign if32.op_in = op;        assign if64.op_in = op;
  assign if32.rs1_value_in = a[31:0];  assign if64.rs1_value_in = a;
  assign if32.rs2_value_in = b[31:0];  assign if64.rs2_value_in = b;
  assign if32.rd_in = rd;        assign if64.rd_in = rd;

  rv32_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) dut32 (.clk(clk), .reset(rst), .bus(if32));
  rv32_muldiv_unit #(.XLEN(64), .BITS_PER_CYCLE(4)) dut64 (.clk(clk), .reset(rst), .bus(if64));

  logic        o_busy, o_valid, o_rdw;
  logic [4:0]  o_rd;
  logic [63:0] o_res;
  assign o_busy  = sel ? if64.busy_out : if32.busy_out;
  assign o_valid = sel ? if64.valid_out : if32.valid_out;
  assign o_rdw   = sel ? if64.rd_write_out : if32.rd_write_out;
  assign o_rd    = sel ? if64.rd_out : if32.rd_out;
  assign o_res   = sel ? if64.result_out : {32'd0, if32.result_out};

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] res;
  } sb_t;
  sb_t exp_q[$];

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    logic [5:0]  lat;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input int xl, input logic [2:0] mop,
                                        input logic [63:0] ai, input logic [63:0] bi);
    logic [63:0] mask, ma, mb, res;
    logic [127:0] ua, ub, sa, sb, p, t;
    logic signed [127:0] ssa, ssb, qs;
    mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    ma = ai & mask;
    mb = bi & mask;
    ua = {64'd0, ma};
    ub = {64'd0, mb};
    sa = ma[xl-1] ? (ua | {64'hFFFF_FFFF_FFFF_FFFF, ~mask}) : ua;
    sb = mb[xl-1] ? (ub | {64'hFFFF_FFFF_FFFF_FFFF, ~mask}) : ub;
    ssa = sa;
    ssb = sb;
    p = '0;
    case (mop)
      3'd0: p = ua * ub;
      3'd1: p = (sa * sb) >> xl;
      3'd2: p = (sa * ub) >> xl;
      3'd3: p = (ua * ub) >> xl;
      3'd4: begin qs = ssa / ssb; p = qs; end
      3'd5: p = ua / ub;
      3'd6: begin qs = ssa % ssb; p = qs; end
      default: p = ua % ub;
    endcase
    t = p;
    res = t[63:0] & mask;
    if (mop[2] && mb == 64'd0) res = mop[1] ? ma : mask;
    return res;
  endfunction

  // Issue one op at posedge+1, track it through the scoreboard, then retire it to IDLE.
  task automatic do_op(input logic s, input logic [2:0] o, input logic [63:0] x,
                       input logic [63:0] y, input logic [4:0] r, input logic [63:0] e,
                       input int lat, input string name);
    int cyc, bcnt;
    sb_t got;
    sel = s; op = o; a = x; b = y; rd = r;
    if (s) v64 = 1'b1; else v32 = 1'b1;
    exp_q.push_back('{rd: r, res: e});
    #1;
    check({name, " busy@accept"}, 64'(o_busy), 64'd1);
    bcnt = 1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (!o_valid && o_busy) bcnt++;
    end while (!o_valid && cyc < 200);
    check({name, " latency"}, 64'(cyc), 64'(lat));
    check({name, " busy cycles"}, 64'(bcnt), 64'(lat));
    check({name, " busy@done"}, 64'(o_busy), 64'd0);
    if (exp_q.size() == 0) begin
      check({name, " scoreboard empty"}, 64'd1, 64'd0);
    end else begin
      got = exp_q.pop_front();
      check({name, " result"}, o_res, got.res);
      check({name, " rd"}, 64'(o_rd), 64'(got.rd));
      check({name, " rd_write"}, 64'(o_rdw), 64'(got.rd != 5'd0));
    end
    @(posedge clk); #1;
    v32 = 1'b0; v64 = 1'b0;
    #1;
    check({name, " valid cleared"}, 64'(o_valid), 64'd0);
  endtask

  function automatic int exp_lat(input int xl, input int iter, input logic [2:0] mop,
                                 input logic [63:0] x, input logic [63:0] y);
    logic [63:0] mask, minv;
    mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    minv = (xl == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    if (mop[2] && (y & mask) == 64'd0) return 1;
    if ((mop == 3'd4 || mop == 3'd6) && (x & mask) == minv && (y & mask) == mask) return 1;
    return iter + 1;
  endfunction

  vec_t vt[20];

  initial begin
    int saw;
    logic [2:0]  ro;
    logic [63:0] ra, rb;
    sb_t got;
    vt = '{
      '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 6'd33},
      '{3'd1, 32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000, 6'd33},
      '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFF, 6'd33},
      '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 6'd33},
      '{3'd4, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD, 6'd33},
      '{3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF, 6'd33},
      '{3'd5, 32'd7,          32'd0,         5'd7,  32'hFFFF_FFFF, 6'd1},
      '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd8,  32'd0,         6'd1},
      '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd9,  32'h8000_0000, 6'd1},
      '{3'd7, 32'd7,          32'd0,         5'd10, 32'd7,         6'd1},
      '{3'd4, 32'd5,          32'd0,         5'd11, 32'hFFFF_FFFF, 6'd1},
      '{3'd6, 32'hFFFF_FFFB,  32'd0,         5'd12, 32'hFFFF_FFFB, 6'd1},
      '{3'd5, 32'd100,        32'd7,         5'd0,  32'd14,        6'd33},
      '{3'd7, 32'd100,        32'd7,         5'd13, 32'd2,         6'd33},
      '{3'd0, 32'd0,          32'h1234_5678, 5'd14, 32'd0,         6'd33},
      '{3'd4, 32'd7,          32'hFFFF_FFFE, 5'd15, 32'hFFFF_FFFD, 6'd33},
      '{3'd6, 32'd7,          32'hFFFF_FFFE, 5'd16, 32'd1,         6'd33},
      '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd17, 32'd0,         6'd33},
      '{3'd3, 32'h8000_0000,  32'd2,         5'd18, 32'd1,         6'd33},
      '{3'd4, 32'h8000_0000,  32'd2,         5'd19, 32'hC000_0000, 6'd33}
    };

    rst = 1'b1; stall = 1'b0; flush = 1'b0; v32 = 1'b0; v64 = 1'b0;
    sel = 1'b0; op = '0; a = '0; b = '0; rd = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check($sformatf("reset%0d valid", s), 64'(o_valid), 64'd0);
      check($sformatf("reset%0d busy", s), 64'(o_busy), 64'd0);
      check($sformatf("reset%0d rd", s), 64'(o_rd), 64'd0);
      check($sformatf("reset%0d rd_write", s), 64'(o_rdw), 64'd0);
      check($sformatf("reset%0d result", s), o_res, 64'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++) begin
      do_op(1'b0, vt[i].op, {32'd0, vt[i].a}, {32'd0, vt[i].b}, vt[i].rd,
            {32'd0, vt[i].exp}, int'(vt[i].lat), $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 10; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = {32'd0, $urandom};
      rb = {32'd0, (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom};
      do_op(1'b0, ro, ra, rb, 5'(i + 1), model(32, ro, ra, rb), exp_lat(32, 32, ro, ra, rb),
            $sformatf("rnd32_%0d", i));
    end
    for (int i = 0; i < 10; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = {$urandom, $urandom};
      rb = (i % 3 == 0) ? 64'($urandom_range(1, 1000)) : {$urandom, $urandom};
      do_op(1'b1, ro, ra, rb, 5'(i + 20), model(64, ro, ra, rb), exp_lat(64, 16, ro, ra, rb),
            $sformatf("rnd64_%0d", i));
    end

    // DONE held by stall: outputs frozen, no re-accept while valid_in stays high.
    sel = 1'b0; op = 3'd0; a = 64'd3; b = 64'd4; rd = 5'd7; v32 = 1'b1;
    exp_q.push_back('{rd: 5'd7, res: 64'd12});
    saw = 0;
    do begin @(posedge clk); #1; saw++; end while (!o_valid && saw < 200);
    got = exp_q.pop_front();
    check("stall first result", o_res, got.res);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("stall%0d valid held", i), 64'(o_valid), 64'd1);
      check($sformatf("stall%0d result held", i), o_res, got.res);
      check($sformatf("stall%0d rd_write held", i), 64'(o_rdw), 64'd1);
      check($sformatf("stall%0d no accept", i), 64'(o_busy), 64'd0);
    end
    stall = 1'b0;
    @(posedge clk); #1;
    v32 = 1'b0;
    #1;
    check("stall release valid", 64'(o_valid), 64'd0);
    check("stall release busy", 64'(o_busy), 64'd0);

    // Flush at c10 of a DIVU aborts it; the next op is accepted right after.
    op = 3'd5; a = 64'd1000; b = 64'd3; rd = 5'd9; v32 = 1'b1;
    saw = 0;
    for (int c = 1; c <= 10; c++) begin @(posedge clk); #1; if (o_valid) saw++; end
    flush = 1'b1; v32 = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    check("flush busy", 64'(o_busy), 64'd0);
    check("flush valid", 64'(o_valid), 64'd0);
    check("flush no early valid", 64'(saw), 64'd0);
    do_op(1'b0, 3'd5, 64'd100, 64'd7, 5'd9, 64'd14, 33, "post-flush divu");

    // Flush beats accept in the same cycle.
    op = 3'd0; a = 64'd5; b = 64'd5; rd = 5'd3; v32 = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    v32 = 1'b0; flush = 1'b0;
    #1;
    check("flush-vs-accept busy", 64'(o_busy), 64'd0);
    saw = 0;
    for (int c = 0; c < 36; c++) begin @(posedge clk); #1; if (o_valid) saw++; end
    check("flush-vs-accept no result", 64'(saw), 64'd0);

    // Async reset mid-RUN on the 64-bit radix-16 unit.
    do_op(1'b1, 3'd0, 64'h0000_0001_0000_0001, 64'd3, 5'd4, 64'h0000_0003_0000_0003, 17,
          "mul64");
    sel = 1'b1; op = 3'd5; a = 64'd1000; b = 64'd7; rd = 5'd6; v64 = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1; v64 = 1'b0;
    #1;
    check("midrun reset valid", 64'(o_valid), 64'd0);
    check("midrun reset busy", 64'(o_busy), 64'd0);
    check("midrun reset rd", 64'(o_rd), 64'd0);
    check("midrun reset rd_write", 64'(o_rdw), 64'd0);
    check("midrun reset result", o_res, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post-reset idle valid", 64'(o_valid), 64'd0);
    do_op(1'b1, 3'd5, 64'd100, 64'd7, 5'd3, 64'd14, 17, "post-reset divu64");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rv32_muldiv_unit.md
Name: rv32_muldiv_unit

Overview:
- Parametrised multi-cycle M-extension functional unit; runs beside the execute stage's single-cycle ALU path.
- Accepts MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU from the execute stage.
- Holds execute via busy_out to the hazard unit while iterating, then presents a registered result with rd tag for the memory stage.
- Generalised in datapath width and radix (bits retired per cycle); has a divide-by-zero/overflow fast path.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- BITS_PER_CYCLE, 1, quotient/multiplier bits per iteration; legal values 1, 2 or 4; must divide XLEN.
- ITER (localparam), XLEN/BITS_PER_CYCLE, iteration cycles per op.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- stall_in  in  1  pipeline stall from hazard unit
- flush_in  in  1  squash from hazard unit
- valid_in  in  1  execute-stage instruction valid and is an M op
- op_in  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1_value_in  in  XLEN  bypassed rs1 operand
- rs2_value_in  in  XLEN  bypassed rs2 operand
- rd_in  in  5  destination register
- busy_out  out  1  combinational; hazard unit must stall IF/ID/EX while high
- valid_out  out  1  registered result valid
- rd_out  out  5  registered destination tag
- rd_write_out  out  1  registered; valid_out && rd_out!=0
- result_out  out  XLEN  registered result

Behaviour:
- Reset: asynchronous, overrides everything. state=IDLE, counter=0, valid_out=0, rd_out=0, rd_write_out=0, result_out=0, internal operand/accumulator regs=0.
- States: IDLE, RUN, DONE.
- Accept: IDLE && valid_in && !stall_in && !flush_in.
  - At the accept edge: capture op, rd, |rs1|, |rs2| per signedness, result-negate flag; counter=ITER.
  - Signedness: MULH, DIV and REM are signed on both operands; MULHSU signs rs1 only.
- busy_out = (IDLE && accept condition) || RUN. Low in DONE and in idle IDLE.
- RUN: each edge retires BITS_PER_CYCLE bits and decrements counter. Multiply is shift-add into a 2*XLEN accumulator; divide is restoring.
  - Edge with counter==1: write result_out (sign-corrected; low half for MUL, high half for MULH*), set valid_out=1, go to DONE.
  - Latency: accept cycle c0; RUN cycles c1..cITER; valid_out high in cITER+1.
  - stall_in does not pause iteration.
- Fast path: DIV/DIVU/REM/REMU with rs2==0, or signed DIV/REM with rs1=MIN and rs2=-1.
  - Goes IDLE→DONE directly at the accept edge; valid_out high in c1.
  - Divide by zero: quotient = all ones, remainder = rs1.
  - Signed overflow: quotient = MIN, remainder = 0.
- DONE: no accept, even though the same instruction still drives valid_in (prevents double issue).
  - !stall_in → IDLE and clear valid_out/rd_write_out at that edge.
  - stall_in → hold all outputs.
- flush_in: at the next edge, state=IDLE and valid_out/rd_write_out=0 from any state, aborting RUN. Flush beats accept in the same cycle; flush beats stall.
- Zero operands are not special-cased; they take the full ITER cycles. rd=0 yields rd_write_out=0 but valid_out=1.
- Reset asserted mid-RUN aborts immediately. After deassertion, no op is in flight until a fresh accept.

Test Plan:
- XLEN=32, BPC=1: MUL rs1=7, rs2=-3, rd=5 → busy_out high 33 cycles (c0..c32); c33 valid_out=1, rd_out=5, result_out=0xFFFFFFEB, rd_write_out=1.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF. MULHU same operands → 0xFFFFFFFE.
- DIV -7/2 → 0xFFFFFFFD. REM -7/2 → 0xFFFFFFFF. DIVU 7/0 → 0xFFFFFFFF at c1 (fast path). REM 0x80000000/-1 → 0 at c1.
- DONE with stall_in high 3 cycles → valid_out and result held; no second accept despite valid_in=1; IDLE after stall drops.
- flush_in at c10 of a DIVU → state IDLE next edge, valid_out never asserts, busy_out low; a new op is accepted the following cycle.
- Async reset pulse mid-RUN (XLEN=64, BPC=4, ITER=16) → all outputs 0 immediately; subsequent DIVU 100/7 → result 14 at c17.
